// File: rtl/lbus_pkg.sv
// Shared LBUS TX definitions: segment geometry, per-segment word layout and
// the byte-lane helpers used by the AXIS-to-LBUS converter.
package lbus_pkg;

  localparam int unsigned NUM_SEG   = 4;
  localparam int unsigned SEG_BYTES = 16;
  localparam int unsigned SEG_WIDTH = 128;
  localparam int unsigned MTY_WIDTH = 4;

  typedef struct packed {
    logic [SEG_WIDTH-1:0] data;
    logic                 ena;
    logic                 sop;
    logic                 eop;
    logic                 err;
    logic [MTY_WIDTH-1:0] mty;
  } seg_t;

  typedef seg_t [NUM_SEG-1:0] word_t;

  function automatic logic [SEG_WIDTH-1:0] byte_reverse(input logic [SEG_WIDTH-1:0] d);
    logic [SEG_WIDTH-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < SEG_BYTES; j++) begin
      r[SEG_WIDTH-1-8*j -: 8] = d[8*j +: 8];
    end
    return r;
  endfunction

  // keep2mty: reversed keep (bit 15 = first byte) must be ones-then-zeros;
  // any other pattern, including all zeros, maps to 0.
  function automatic logic [MTY_WIDTH-1:0] keep2mty(input logic [SEG_BYTES-1:0] keep_rev);
    logic [MTY_WIDTH-1:0] mty;
    mty = '0;
    for (int unsigned n = 0; n < SEG_BYTES; n++) begin
      if (keep_rev == ({SEG_BYTES{1'b1}} << n)) mty = MTY_WIDTH'(n);
    end
    return mty;
  endfunction

endpackage

// File: rtl/axis_to_lbus_tx_if.sv
// Bus bundles for the TX converter: 512-bit AXI4-Stream input and
// 4-segment LBUS output, each with master/slave views.
interface axis512_if;
  import lbus_pkg::*;
  logic [NUM_SEG*SEG_WIDTH-1:0] s_axis_tdata;
  logic [NUM_SEG*SEG_BYTES-1:0] s_axis_tkeep;
  logic                         s_axis_tlast;
  logic                         s_axis_tuser;
  logic                         s_axis_tvalid;
  logic                         s_axis_tready;

  modport master (output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
                  s_axis_tvalid, input s_axis_tready);
  modport slave  (input s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
                  s_axis_tvalid, output s_axis_tready);
endinterface

interface lbus_tx_if;
  import lbus_pkg::*;
  logic [NUM_SEG*SEG_WIDTH-1:0] lbus_data;
  logic [NUM_SEG-1:0]           lbus_ena;
  logic [NUM_SEG-1:0]           lbus_sop;
  logic [NUM_SEG-1:0]           lbus_eop;
  logic [NUM_SEG-1:0]           lbus_err;
  logic [NUM_SEG*MTY_WIDTH-1:0] lbus_mty;
  logic                         lbus_rdy;

  modport master (output lbus_data, lbus_ena, lbus_sop, lbus_eop, lbus_err, lbus_mty,
                  input lbus_rdy);
  modport slave  (input lbus_data, lbus_ena, lbus_sop, lbus_eop, lbus_err, lbus_mty,
                  output lbus_rdy);
endinterface

// File: rtl/axis_seg_encode.sv
// One LBUS segment from a 16-byte AXIS slice: byte-reversed data, enable and
// empty-byte count.
module axis_seg_encode
  import lbus_pkg::*;
(
  input  logic [SEG_WIDTH-1:0] data_in,
  input  logic [SEG_BYTES-1:0] keep_in,
  output logic [SEG_WIDTH-1:0] data_out,
  output logic                 ena,
  output logic [MTY_WIDTH-1:0] mty
);

  logic [SEG_BYTES-1:0] keep_rev;

  always_comb begin
    keep_rev = '0;
    for (int unsigned j = 0; j < SEG_BYTES; j++) begin
      keep_rev[SEG_BYTES-1-j] = keep_in[j];
    end
    data_out = byte_reverse(data_in);
    ena      = |keep_in;
    mty      = keep2mty(keep_rev);
  end

endmodule

// File: rtl/axis_to_lbus_tx.sv
// AXIS 512-bit to CMAC LBUS TX converter with registered output and a
// one-entry skid buffer so tready never depends combinationally on lbus_rdy.
module axis_to_lbus_tx
  import lbus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  axis512_if.slave   s_axis,
  lbus_tx_if.master  lbus,
  output logic       proto_err
);

  logic [NUM_SEG-1:0][SEG_WIDTH-1:0] enc_data;
  logic [NUM_SEG-1:0]                enc_ena;
  logic [NUM_SEG-1:0][MTY_WIDTH-1:0] enc_mty;

  for (genvar i = 0; i < NUM_SEG; i++) begin : g_seg
    axis_seg_encode u_enc (
      .data_in  (s_axis.s_axis_tdata[SEG_WIDTH*i +: SEG_WIDTH]),
      .keep_in  (s_axis.s_axis_tkeep[SEG_BYTES*i +: SEG_BYTES]),
      .data_out (enc_data[i]),
      .ena      (enc_ena[i]),
      .mty      (enc_mty[i])
    );
  end

  logic                         in_pkt_q, in_pkt_d;
  logic                         or_valid_q, or_valid_d;
  logic                         sk_valid_q, sk_valid_d;
  logic                         proto_err_q, proto_err_d;
  word_t                        or_q, or_d;
  word_t                        sk_q, sk_d;
  word_t                        beat;
  logic                         tready, accept, beat_valid, malformed;
  logic [NUM_SEG-1:0]           beat_ena;
  logic [1:0]                   eop_seg;
  logic [NUM_SEG*SEG_BYTES-1:0] keep;

  assign tready               = !sk_valid_q && !rst;
  assign s_axis.s_axis_tready = tready;
  assign proto_err            = proto_err_q;

  always_comb begin
    keep       = s_axis.s_axis_tkeep;
    accept     = s_axis.s_axis_tvalid && tready;
    beat_valid = accept && (|keep);
    // Non-last beats are always presented as full words, even if keep is short.
    beat_ena   = s_axis.s_axis_tlast ? enc_ena : '1;
    malformed  = (keep == '0) || (!s_axis.s_axis_tlast && (keep != '1)) ||
                 ((keep & (keep + 64'd1)) != '0);

    eop_seg = '0;
    for (int unsigned i = 0; i < NUM_SEG; i++) begin
      if (beat_ena[i]) eop_seg = 2'(i);
    end

    beat = '0;
    for (int unsigned i = 0; i < NUM_SEG; i++) begin
      beat[i].data = enc_data[i];
      beat[i].ena  = beat_ena[i];
    end
    beat[0].sop = beat_ena[0] && !in_pkt_q;
    if (s_axis.s_axis_tlast) begin
      beat[eop_seg].eop = 1'b1;
      beat[eop_seg].err = s_axis.s_axis_tuser;
      beat[eop_seg].mty = enc_mty[eop_seg];
    end

    in_pkt_d = in_pkt_q;
    if (accept) begin
      if (s_axis.s_axis_tlast) in_pkt_d = 1'b0;
      else if (|keep)          in_pkt_d = 1'b1;
    end
    proto_err_d = proto_err_q || (accept && malformed);

    or_d       = or_q;
    or_valid_d = or_valid_q;
    sk_d       = sk_q;
    sk_valid_d = sk_valid_q;
    if (!or_valid_q || lbus.lbus_rdy) begin
      if (sk_valid_q) begin
        or_d       = sk_q;
        or_valid_d = 1'b1;
        sk_valid_d = 1'b0;
      end else begin
        or_valid_d = beat_valid;
        if (beat_valid) or_d = beat;
      end
    end else if (beat_valid) begin
      sk_d       = beat;
      sk_valid_d = 1'b1;
    end
  end

  always_comb begin
    lbus.lbus_data = '0;
    lbus.lbus_ena  = '0;
    lbus.lbus_sop  = '0;
    lbus.lbus_eop  = '0;
    lbus.lbus_err  = '0;
    lbus.lbus_mty  = '0;
    if (or_valid_q) begin
      for (int unsigned i = 0; i < NUM_SEG; i++) begin
        lbus.lbus_data[SEG_WIDTH*i +: SEG_WIDTH] = or_q[i].data;
        lbus.lbus_ena[i]                         = or_q[i].ena;
        lbus.lbus_sop[i]                         = or_q[i].sop;
        lbus.lbus_eop[i]                         = or_q[i].eop;
        lbus.lbus_err[i]                         = or_q[i].err;
        lbus.lbus_mty[MTY_WIDTH*i +: MTY_WIDTH]  = or_q[i].mty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt_q    <= 1'b0;
      or_valid_q  <= 1'b0;
      sk_valid_q  <= 1'b0;
      proto_err_q <= 1'b0;
      or_q        <= '0;
      sk_q        <= '0;
    end else begin
      in_pkt_q    <= in_pkt_d;
      or_valid_q  <= or_valid_d;
      sk_valid_q  <= sk_valid_d;
      proto_err_q <= proto_err_d;
      or_q        <= or_d;
      sk_q        <= sk_d;
    end
  end

endmodule

// File: tb/tb_axis_to_lbus_tx.sv
// Bench for axis_to_lbus_tx: directed packets plus random traffic checked
// against a byte-count based reference model and an ordered scoreboard.
module tb_axis_to_lbus_tx;
  import lbus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic proto_err;

  axis512_if s_axis();
  lbus_tx_if lbus();

  axis_to_lbus_tx dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (s_axis),
    .lbus      (lbus),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         user;
  } beat_t;

  typedef struct {
    logic [511:0] data;
    logic [3:0]   ena;
    logic [3:0]   sop;
    logic [3:0]   eop;
    logic [3:0]   err;
    logic [15:0]  mty;
  } exp_t;

  beat_t bq[$];
  exp_t  exp_q[$];
  exp_t  xlog[$];
  int    checks = 0;
  int    failures = 0;
  bit    m_in_pkt = 1'b0;
  bit    acc, xfer, obs_tready;
  int    n_xfer = 0;
  bit    stall_armed = 1'b0;
  logic [543:0] snap;

  task automatic chk(input string tag, input logic [543:0] obs, input logic [543:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [543:0] cur_out();
    return {lbus.lbus_data, lbus.lbus_ena, lbus.lbus_sop, lbus.lbus_eop,
            lbus.lbus_err, lbus.lbus_mty};
  endfunction

  // Expected LBUS word derived from the byte count of an accepted beat.
  task automatic model_accept(input beat_t b);
    exp_t e;
    int n, segs;
    n = $countones(b.keep);
    if (n == 0) begin
      if (b.last) m_in_pkt = 1'b0;
      return;
    end
    segs = b.last ? (n + 15) / 16 : 4;
    e = '{default: '0};
    e.ena = 4'((1 << segs) - 1);
    e.sop = {3'b000, !m_in_pkt};
    if (b.last) begin
      e.eop = 4'(1 << (segs - 1));
      e.err = b.user ? e.eop : 4'b0000;
      e.mty[4*(segs-1) +: 4] = 4'(16 * segs - n);
    end
    for (int i = 0; i < segs; i++)
      for (int j = 0; j < 16; j++)
        e.data[128*i + 127 - 8*j -: 8] = b.data[8*(16*i + j) +: 8];
    m_in_pkt = !b.last;
    exp_q.push_back(e);
  endtask

  task automatic observe();
    exp_t e, w;
    logic [511:0] mask;
    beat_t b;
    logic [543:0] cur;
    acc = 1'b0;
    xfer = 1'b0;
    obs_tready = s_axis.s_axis_tready;
    cur = cur_out();
    if (rst) begin
      stall_armed = 1'b0;
      return;
    end
    if (stall_armed) chk("stall_hold", cur, snap);
    if (lbus.lbus_rdy && (|lbus.lbus_ena)) begin
      xfer = 1'b1;
      n_xfer++;
      w = '{lbus.lbus_data, lbus.lbus_ena, lbus.lbus_sop, lbus.lbus_eop,
            lbus.lbus_err, lbus.lbus_mty};
      xlog.push_back(w);
      chk("word_expected", 544'(exp_q.size() > 0), 544'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mask = '0;
        for (int i = 0; i < 4; i++) if (e.ena[i]) mask[128*i +: 128] = '1;
        chk("ena", 544'(w.ena), 544'(e.ena));
        chk("sop", 544'(w.sop), 544'(e.sop));
        chk("eop", 544'(w.eop), 544'(e.eop));
        chk("err", 544'(w.err), 544'(e.err));
        chk("mty", 544'(w.mty), 544'(e.mty));
        chk("data", 544'(w.data & mask), 544'(e.data & mask));
      end
    end
    stall_armed = !lbus.lbus_rdy && (|lbus.lbus_ena);
    snap = cur;
    if (s_axis.s_axis_tvalid && s_axis.s_axis_tready) begin
      acc = 1'b1;
      b.data = s_axis.s_axis_tdata;
      b.keep = s_axis.s_axis_tkeep;
      b.last = s_axis.s_axis_tlast;
      b.user = s_axis.s_axis_tuser;
      model_accept(b);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input beat_t b);
    s_axis.s_axis_tdata  = b.data;
    s_axis.s_axis_tkeep  = b.keep;
    s_axis.s_axis_tlast  = b.last;
    s_axis.s_axis_tuser  = b.user;
    s_axis.s_axis_tvalid = 1'b1;
  endtask

  task automatic add_pkt(input int len, input bit user);
    beat_t b;
    int rem, n;
    rem = len;
    while (rem > 0) begin
      n = (rem > 64) ? 64 : rem;
      for (int w = 0; w < 16; w++) b.data[32*w +: 32] = $urandom;
      b.keep = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
      b.last = (rem == n);
      b.user = b.last ? user : 1'b0;
      bq.push_back(b);
      rem -= n;
    end
  endtask

  task automatic run_stream(input int p_valid, input int p_rdy, input int budget);
    int c;
    c = 0;
    while ((bq.size() > 0 || exp_q.size() > 0) && c < budget) begin
      lbus.lbus_rdy = ($urandom_range(99) < p_rdy);
      if (bq.size() > 0 && ($urandom_range(99) < p_valid)) drive(bq[0]);
      else s_axis.s_axis_tvalid = 1'b0;
      cyc();
      if (acc) void'(bq.pop_front());
      c++;
    end
    s_axis.s_axis_tvalid = 1'b0;
    lbus.lbus_rdy = 1'b1;
    chk("stream_drained", 544'({bq.size() == 0, exp_q.size() == 0}), 544'(2'b11));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    int stall_acc, x0;
    s_axis.s_axis_tdata  = '0;
    s_axis.s_axis_tkeep  = '0;
    s_axis.s_axis_tlast  = 1'b0;
    s_axis.s_axis_tuser  = 1'b0;
    s_axis.s_axis_tvalid = 1'b0;
    lbus.lbus_rdy        = 1'b1;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_tready", 544'(s_axis.s_axis_tready), 544'(0));
    chk("rst_outputs", cur_out(), '0);
    chk("rst_proto_err", 544'(proto_err), 544'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", 544'(s_axis.s_axis_tready), 544'(1));
    @(posedge clk);
    #1;

    // 64-byte single beat, one-cycle latency
    add_pkt(64, 1'b0);
    b = bq.pop_front();
    xlog.delete();
    drive(b);
    cyc();
    chk("t1_accept", 544'(acc), 544'(1));
    s_axis.s_axis_tvalid = 1'b0;
    cyc();
    chk("t1_latency", 544'(xfer), 544'(1));
    chk("t1_count", 544'(xlog.size()), 544'(1));
    chk("t1_ena", 544'(xlog[0].ena), 544'(4'b1111));
    chk("t1_sop", 544'(xlog[0].sop), 544'(4'b0001));
    chk("t1_eop", 544'(xlog[0].eop), 544'(4'b1000));
    chk("t1_mty", 544'(xlog[0].mty), 544'(0));
    chk("t1_err", 544'(xlog[0].err), 544'(0));
    chk("t1_byte0", 544'(xlog[0].data[127:120]), 544'(b.data[7:0]));

    // 65-byte packet
    xlog.delete();
    add_pkt(65, 1'b0);
    run_stream(100, 100, 20);
    chk("t2_count", 544'(xlog.size()), 544'(2));
    chk("t2_w1_ena", 544'(xlog[0].ena), 544'(4'b1111));
    chk("t2_w1_sop", 544'(xlog[0].sop), 544'(4'b0001));
    chk("t2_w1_eop", 544'(xlog[0].eop), 544'(4'b0000));
    chk("t2_w2_ena", 544'(xlog[1].ena), 544'(4'b0001));
    chk("t2_w2_eop", 544'(xlog[1].eop), 544'(4'b0001));
    chk("t2_w2_mty", 544'(xlog[1].mty[3:0]), 544'(15));

    // 100-byte packet with error
    xlog.delete();
    add_pkt(100, 1'b1);
    run_stream(100, 100, 20);
    chk("t3_count", 544'(xlog.size()), 544'(2));
    chk("t3_w1_err", 544'(xlog[0].err), 544'(0));
    chk("t3_w2_ena", 544'(xlog[1].ena), 544'(4'b0111));
    chk("t3_w2_eop", 544'(xlog[1].eop), 544'(4'b0100));
    chk("t3_w2_mty", 544'(xlog[1].mty[11:8]), 544'(12));
    chk("t3_w2_err", 544'(xlog[1].err), 544'(4'b0100));

    // Back-to-back 64B packets with a 3-cycle stall
    for (int k = 0; k < 6; k++) add_pkt(64, k[0]);
    stall_acc = 0;
    x0 = n_xfer;
    for (int c = 0; c < 40 && (bq.size() > 0 || exp_q.size() > 0); c++) begin
      lbus.lbus_rdy = !(c >= 3 && c <= 5);
      if (bq.size() > 0) drive(bq[0]);
      else s_axis.s_axis_tvalid = 1'b0;
      cyc();
      if (acc) void'(bq.pop_front());
      if (c >= 3 && c <= 5 && acc) stall_acc++;
      if (c == 4 || c == 5) chk("bp_tready_low", 544'(obs_tready), 544'(0));
    end
    s_axis.s_axis_tvalid = 1'b0;
    lbus.lbus_rdy = 1'b1;
    chk("bp_extra_beats", 544'(stall_acc), 544'(1));
    chk("bp_words", 544'(n_xfer - x0), 544'(6));
    chk("bp_drained", 544'({bq.size() == 0, exp_q.size() == 0}), 544'(2'b11));

    // Random traffic with random valid gaps and backpressure
    for (int k = 0; k < 14; k++) add_pkt(int'($urandom_range(200, 1)), 1'($urandom));
    run_stream(70, 65, 3000);
    chk("proto_err_clean", 544'(proto_err), 544'(0));

    // tlast beat with empty keep
    xlog.delete();
    add_pkt(128, 1'b0);
    b = bq[1];
    b.keep = '0;
    bq[1] = b;
    add_pkt(64, 1'b0);
    run_stream(100, 100, 30);
    chk("t6_proto_err", 544'(proto_err), 544'(1));
    chk("t6_count", 544'(xlog.size()), 544'(2));
    chk("t6_w1_eop", 544'(xlog[0].eop), 544'(0));
    chk("t6_w2_sop", 544'(xlog[1].sop), 544'(4'b0001));
    chk("t6_w2_eop", 544'(xlog[1].eop), 544'(4'b1000));

    // Reset mid-packet with output and skid registers full
    add_pkt(192, 1'b0);
    lbus.lbus_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bq.size() > 0) drive(bq[0]);
      cyc();
      if (acc) void'(bq.pop_front());
    end
    chk("t7_skid_full", 544'(obs_tready), 544'(0));
    rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("t7_rst_outputs", cur_out(), '0);
    chk("t7_rst_tready", 544'(s_axis.s_axis_tready), 544'(0));
    chk("t7_rst_proto_err", 544'(proto_err), 544'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_axis.s_axis_tvalid = 1'b0;
    bq.delete();
    exp_q.delete();
    m_in_pkt = 1'b0;
    stall_armed = 1'b0;
    xlog.delete();
    add_pkt(64, 1'b0);
    run_stream(100, 100, 20);
    chk("t7_count", 544'(xlog.size()), 544'(1));
    chk("t7_sop", 544'(xlog[0].sop), 544'(4'b0001));
    chk("t7_eop", 544'(xlog[0].eop), 544'(4'b1000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
